// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling; emits a one-cycle write strobe per good word.
// Latency: strobe 2+N/2+(WIDTH+1)N edges after the start edge; no backpressure (overflow belongs to the FIFO).
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int WIDTH        = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_rx,
    output logic [WIDTH-1:0] o_data,
    output logic             o_set,
    output logic             o_frame_err,
    output logic             o_busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    logic             rx_m;
    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] shreg;

    // Resetting to 1 keeps a reset release from looking like a start edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= i_rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_set       <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_set       <= 1'b0;
            o_frame_err <= 1'b0;
            if (!i_en) begin
                state <= S_IDLE;
                cnt   <= '0;
                idx   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!rx_s) begin
                            state <= S_START;
                            cnt   <= '0;
                        end
                    end
                    S_START: begin
                        if (cnt == CNT_HALF) begin
                            cnt   <= '0;
                            idx   <= '0;
                            state <= rx_s ? S_IDLE : S_DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (cnt == CNT_FULL) begin
                            // Right shift: the first bit received ends up in the LSB.
                            cnt   <= '0;
                            shreg <= {rx_s, shreg[WIDTH-1:1]};
                            idx   <= idx + 1'b1;
                            if (idx == IDX_LAST) begin
                                state <= S_STOP;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (cnt == CNT_FULL) begin
                            cnt <= '0;
                            if (rx_s) begin
                                o_data <= shreg;
                                o_set  <= 1'b1;
                                state  <= S_IDLE;
                            end else begin
                                o_frame_err <= 1'b1;
                                state       <= S_WAIT;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_WAIT: begin
                        // A held-low line (break) parks here, so it reports only once.
                        if (rx_s) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: randomized and directed frames, scoreboard queue of expected strobes checked by a monitor.
module tb_uart_rx;
    localparam int N = 16;
    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_en  = 1'b0;
    logic         i_rx  = 1'b1;
    logic [W-1:0] o_data;
    logic         o_set;
    logic         o_frame_err;
    logic         o_busy;

    uart_rx #(.CLKS_PER_BIT(N), .WIDTH(W)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_set      (o_set),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit           err;
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] fifo_q[$];
    int           set_cyc[$];
    logic [W-1:0] last_good = '0;
    logic [W-1:0] prev_data = '0;
    int           cyc = 0;
    int           n_chk = 0;
    int           n_pass = 0;

    always @(posedge i_clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: every strobe must match the head of the scoreboard in kind, data and cycle.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst) begin
            if (o_data !== prev_data && !o_set) chk("data_stable", o_data, prev_data);
            prev_data = o_data;
            if (o_set || o_frame_err) begin
                chk("strobe_exclusive", o_set & o_frame_err, 0);
                chk("sb_nonempty", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("strobe_kind", o_frame_err, e.err);
                    chk("strobe_data", o_data, e.data);
                    chk("strobe_cycle", cyc, e.cyc);
                    if (o_set) begin
                        chk("busy_at_set", o_busy, 0);
                        fifo_q.push_back(o_data);
                        set_cyc.push_back(cyc);
                    end
                end
            end
        end else begin
            prev_data = '0;
        end
    end

    // mode 0: normal frame; 1: i_en dropped for one cycle in data bit 3; 2: reset asserted in data bit 3.
    task automatic send_frame(input logic [W-1:0] d, input logic stop, input int mode);
        exp_t e;
        e.cyc  = cyc + 1 + 2 + N / 2 + (W + 1) * N;
        e.err  = !stop;
        e.data = stop ? d : last_good;
        if (mode == 0) begin
            sbq.push_back(e);
            if (stop) last_good = d;
        end
        i_rx = 1'b0;
        tick();
        tick();
        chk("busy_before_edge2", o_busy, 0);
        tick();
        chk("busy_after_edge2", o_busy, 1);
        repeat (N - 3) tick();
        for (int k = 0; k < W; k++) begin
            i_rx = d[k];
            if (mode != 0 && k == 3) begin
                repeat (N / 2) tick();
                if (mode == 1) begin
                    i_en = 1'b0;
                    tick();
                    i_en = 1'b1;
                    chk("busy_after_en_drop", o_busy, 0);
                    repeat (N / 2 - 1) tick();
                end else begin
                    #3 i_rst = 1'b1;
                    #1;
                    chk("rst_busy", o_busy, 0);
                    chk("rst_set", o_set, 0);
                    chk("rst_err", o_frame_err, 0);
                    chk("rst_data", o_data, 0);
                    i_rx = 1'b1;
                    repeat (3) tick();
                    i_rst = 1'b0;
                    last_good = '0;
                    repeat (2 * N) tick();
                    return;
                end
            end else begin
                repeat (N) tick();
            end
        end
        i_rx = stop;
        repeat (N) tick();
    endtask

    initial begin
        logic [W-1:0] d;
        logic         stop;
        int           gap;

        repeat (3) tick();
        chk("reset_data", o_data, 0);
        chk("reset_set", o_set, 0);
        chk("reset_err", o_frame_err, 0);
        chk("reset_busy", o_busy, 0);
        i_rst = 1'b0;
        i_en  = 1'b1;
        repeat (N) tick();

        send_frame(8'hA5, 1'b1, 0);
        i_rx = 1'b1;
        repeat (2 * N) tick();

        // Glitch shorter than half a bit must be rejected at mid start bit.
        i_rx = 1'b0;
        repeat (3) tick();
        chk("glitch_busy_rise", o_busy, 1);
        tick();
        i_rx = 1'b1;
        repeat (6) tick();
        chk("glitch_busy_held", o_busy, 1);
        tick();
        chk("glitch_busy_fall", o_busy, 0);
        repeat (2 * N) tick();

        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h3C, 1'b0, 0);
        repeat (300) tick();
        chk("data_held_after_break", o_data, 8'h11);
        i_rx = 1'b1;
        repeat (2 * N) tick();
        send_frame(8'h5A, 1'b1, 0);
        i_rx = 1'b1;
        repeat (2 * N) tick();

        fifo_q.delete();
        set_cyc.delete();
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        i_rx = 1'b1;
        repeat (2 * N) tick();
        chk("b2b_count", fifo_q.size(), 2);
        chk("b2b_first", fifo_q.size() > 0 ? fifo_q[0] : 8'hxx, 8'h00);
        chk("b2b_second", fifo_q.size() > 1 ? fifo_q[1] : 8'hxx, 8'hFF);
        chk("b2b_spacing", set_cyc.size() > 1 ? set_cyc[1] - set_cyc[0] : 0, 10 * N);

        // Bits 3..7 high so the line stays idle once the aborted frame is dropped.
        send_frame(8'hF8, 1'b1, 1);
        i_rx = 1'b1;
        repeat (2 * N) tick();
        send_frame(8'h7E, 1'b1, 0);
        i_rx = 1'b1;
        repeat (2 * N) tick();

        send_frame(8'h96, 1'b1, 2);

        for (int i = 0; i < 20; i++) begin
            d    = W'($urandom);
            stop = ($urandom_range(3) != 0);
            send_frame(d, stop, 0);
            i_rx = 1'b1;
            gap  = stop ? $urandom_range(2 * N, 0) : $urandom_range(3 * N, N);
            repeat (gap) tick();
        end

        i_rx = 1'b1;
        repeat (4 * N) tick();
        chk("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
